// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register-file scoreboard.
//   DEF_DATA_W / DEF_DEPTH : default register width and register count
//   reset_value()          : value each register takes while reset is held
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 32;

  // Register i resets to its own index; register 0 therefore resets to 0.
  // The caller truncates or zero-extends to its data width.
  function automatic logic [63:0] reset_value(input int unsigned idx);
    return 64'(idx);
  endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Bus bundle for the register-file scoreboard.
//   read ports   : rd_addr1/2 in, rd_data1/2 and rd_busy1/2 out
//   write-back   : we, wr_addr, wr_data
//   issue        : iss_valid, iss_addr (marks a destination busy)
//   control      : flush clears every busy bit
//   status       : busy_count, number of busy registers
// master = the pipeline driving the block, slave = the block itself.
interface regfile_scoreboard_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = $clog2(DEF_DEPTH),
  parameter int CNT_W  = $clog2(DEF_DEPTH + 1)
);

  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              rd_busy1;
  logic              rd_busy2;
  logic              we;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              iss_valid;
  logic [ADDR_W-1:0] iss_addr;
  logic              flush;
  logic [CNT_W-1:0]  busy_count;

  modport master (
    output rd_addr1, rd_addr2, we, wr_addr, wr_data, iss_valid, iss_addr, flush,
    input  rd_data1, rd_data2, rd_busy1, rd_busy2, busy_count
  );

  modport slave (
    input  rd_addr1, rd_addr2, we, wr_addr, wr_data, iss_valid, iss_addr, flush,
    output rd_data1, rd_data2, rd_busy1, rd_busy2, busy_count
  );

endinterface

// File: rtl/rf_busy_tracker.sv
// Per-register busy bits plus a running count of busy registers.
//   clk, rst       : clock, synchronous active-low reset
//   iss_valid_i/iss_addr_i : set the busy bit of a destination
//   we_i/wr_addr_i : write-back, clears the busy bit of its target
//   flush_i        : clears every busy bit (wins over a same-cycle issue)
//   busy_o         : registered busy vector
//   busy_count_o   : registered population count of busy_o
module rf_busy_tracker #(
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int ZERO_REG = 1,
  parameter int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_valid_i,
  input  logic [ADDR_W-1:0] iss_addr_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic              flush_i,
  output logic [DEPTH-1:0]  busy_o,
  output logic [CNT_W-1:0]  busy_count_o
);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             iss_en;
  logic             inc;
  logic             dec;

  always_comb begin
    iss_en = iss_valid_i && !((ZERO_REG != 0) && (iss_addr_i == '0));

    // Clear first, then set: an issue and a write-back to the same register
    // leave it busy because the issue is the newer producer.
    busy_d = busy_q;
    if (we_i)   busy_d[wr_addr_i]  = 1'b0;
    if (iss_en) busy_d[iss_addr_i] = 1'b1;

    // Track the population incrementally so the count never needs a
    // DEPTH-wide adder tree; it can only move by one per cycle.
    inc = iss_en && !busy_q[iss_addr_i];
    dec = we_i && busy_q[wr_addr_i] && !(iss_en && (iss_addr_i == wr_addr_i));
    count_d = count_q + CNT_W'(inc) - CNT_W'(dec);

    if (flush_i) begin
      busy_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign busy_o       = busy_q;
  assign busy_count_o = count_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with two asynchronous read ports, one write-back port and a
// busy scoreboard for in-flight producers.
//   clk, rst : clock, synchronous active-low reset
//   bus      : slave side of regfile_scoreboard_if (reads, write-back,
//              issue, flush, busy_count)
// Parameters: DATA_W, DEPTH (power of two, >= 4), ADDR_W, ZERO_REG (register
// 0 hard-wired to zero), BYPASS (forward same-cycle write data to reads).
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic               clk,
  input  logic               rst,
  regfile_scoreboard_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  // Plain flops: two asynchronous read ports rule out synchronous RAM macros.
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic              wr_en;
  logic [DATA_W-1:0] rd1, rd2;
  logic              bsy1, bsy2;

  assign wr_en = bus.we && !((ZERO_REG != 0) && (bus.wr_addr == '0));

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[bus.wr_addr] = bus.wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= DATA_W'(reset_value(i));
    end else begin
      mem_q <= mem_d;
    end
  end

  rf_busy_tracker #(
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG),
    .CNT_W    (CNT_W)
  ) u_busy (
    .clk          (clk),
    .rst          (rst),
    .iss_valid_i  (bus.iss_valid),
    .iss_addr_i   (bus.iss_addr),
    .we_i         (bus.we),
    .wr_addr_i    (bus.wr_addr),
    .flush_i      (bus.flush),
    .busy_o       (busy),
    .busy_count_o (bus.busy_count)
  );

  // Busy is reported from the registered bits only; data may be bypassed.
  always_comb begin
    rd1  = mem_q[bus.rd_addr1];
    bsy1 = busy[bus.rd_addr1];
    if ((BYPASS != 0) && bus.we && (bus.wr_addr == bus.rd_addr1)) rd1 = bus.wr_data;
    if ((ZERO_REG != 0) && (bus.rd_addr1 == '0)) begin
      rd1  = '0;
      bsy1 = 1'b0;
    end
  end

  always_comb begin
    rd2  = mem_q[bus.rd_addr2];
    bsy2 = busy[bus.rd_addr2];
    if ((BYPASS != 0) && bus.we && (bus.wr_addr == bus.rd_addr2)) rd2 = bus.wr_data;
    if ((ZERO_REG != 0) && (bus.rd_addr2 == '0)) begin
      rd2  = '0;
      bsy2 = 1'b0;
    end
  end

  assign bus.rd_data1 = rd1;
  assign bus.rd_data2 = rd2;
  assign bus.rd_busy1 = bsy1;
  assign bus.rd_busy2 = bsy2;

endmodule
